// File: rtl/edge_pulse_pkg.sv
// Shared definitions for the edge_pulse generator: edge-select encodings,
// channel state encoding, parameter limits and the edge-select helper.
package edge_pulse_pkg;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } chan_state_t;

    localparam int PULSE_LEN_MIN = 1;
    localparam int PULSE_LEN_MAX = 255;
    localparam int CHANNELS_MAX  = 32;

    function automatic logic edge_sel(input logic [1:0] mode,
                                      input logic       rise,
                                      input logic       fall);
        logic sel;
        sel = 1'b0;
        case (mode)
            EDGE_RISE: sel = rise;
            EDGE_FALL: sel = fall;
            EDGE_BOTH: sel = rise | fall;
            default:   sel = 1'b0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/edge_pulse_chan.sv
// One edge_pulse channel: optional synchroniser (EDGE_PULSE_SYNC_EN), edge detect, pulse counter, sticky flag.
// Pulse rises one edge after the input transition is sampled (+2 with the synchroniser); no backpressure.
module edge_pulse_chan
    import edge_pulse_pkg::*;
#(
    parameter int PULSE_LEN = 1,
    parameter int CNT_W     = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sig,
    input  logic [1:0] mode,
    input  logic       clr,
    output logic       pulse,
    output logic       sticky
);

    localparam logic [CNT_W-1:0] LOAD = CNT_W'(PULSE_LEN);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic sig_s;
    logic arm_ok;

`ifdef EDGE_PULSE_SYNC_EN
    logic [1:0] sync;
    logic [1:0] warm;

    // Arming waits until both synchroniser stages hold post-reset samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync <= 2'b00;
            warm <= 2'd0;
        end else begin
            sync <= {sync[0], sig};
            if (warm != 2'd2) begin
                warm <= warm + 2'd1;
            end
        end
    end

    assign sig_s  = sync[1];
    assign arm_ok = (warm == 2'd2);
`else
    assign sig_s  = sig;
    assign arm_ok = 1'b1;
`endif

    logic             prev;
    logic             arm;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    chan_state_t      state;
    chan_state_t      state_nxt;
    logic             sticky_nxt;
    logic             rise;
    logic             fall;
    logic             hit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev   <= 1'b0;
            arm    <= 1'b0;
            cnt    <= '0;
            state  <= ST_IDLE;
            sticky <= 1'b0;
        end else begin
            prev   <= sig_s;
            arm    <= arm_ok;
            cnt    <= cnt_nxt;
            state  <= state_nxt;
            sticky <= sticky_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        rise       = sig_s & ~prev;
        fall       = ~sig_s & prev;
        hit        = arm & edge_sel(mode, rise, fall);
        sticky_nxt = hit | (sticky & ~clr);

        // Off mode also truncates a pulse that is already running.
        if (mode == EDGE_OFF) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
        end else if (hit) begin
            state_nxt = ST_ACTIVE;
            cnt_nxt   = LOAD;
        end else begin
            case (state)
                ST_ACTIVE: begin
                    cnt_nxt = cnt - ONE;
                    if (cnt == ONE) begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign pulse = (state == ST_ACTIVE);

endmodule

// File: rtl/edge_pulse.sv
// Multi-channel edge-to-pulse generator; EDGE_PULSE_SYNC_EN adds a two-flop input synchroniser.
// Pulse latency one edge (three with synchroniser); no backpressure, outputs are free-running strobes.
module edge_pulse
    import edge_pulse_pkg::*;
#(
    parameter int CHANNELS  = 4,
    parameter int PULSE_LEN = 1,
    parameter int CNT_W     = $clog2(PULSE_LEN + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [CHANNELS-1:0]   i_sig,
    input  logic [2*CHANNELS-1:0] i_mode,
    input  logic [CHANNELS-1:0]   i_clr,
    output logic [CHANNELS-1:0]   o_pulse,
    output logic [CHANNELS-1:0]   o_sticky,
    output logic                  o_any
);

    if (PULSE_LEN < PULSE_LEN_MIN || PULSE_LEN > PULSE_LEN_MAX) begin : g_bad_len
        $error("edge_pulse: PULSE_LEN out of range");
    end

    if (CHANNELS < 1 || CHANNELS > CHANNELS_MAX) begin : g_bad_chan
        $error("edge_pulse: CHANNELS out of range");
    end

    for (genvar n = 0; n < CHANNELS; n++) begin : g_chan
        edge_pulse_chan #(
            .PULSE_LEN (PULSE_LEN),
            .CNT_W     (CNT_W)
        ) u_chan (
            .clk    (i_clk),
            .rst_n  (i_rst_n),
            .sig    (i_sig[n]),
            .mode   (i_mode[2*n+1:2*n]),
            .clr    (i_clr[n]),
            .pulse  (o_pulse[n]),
            .sticky (o_sticky[n])
        );
    end

    assign o_any = |o_pulse;

endmodule
